// File: rtl/hub75_pkg.sv
// hub75_pkg: shared geometry defaults, pixel type and framebuffer state encoding
package hub75_pkg;
  localparam int DEF_COLS = 32;
  localparam int DEF_HALF_ROWS = 8;
  localparam int DEF_COL_W = $clog2(DEF_COLS);
  localparam int DEF_ROW_W = $clog2(DEF_HALF_ROWS);
  typedef logic [2:0] rgb_t;
  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fb_state_t;
endpackage

// File: rtl/fb_bank.sv
// fb_bank: one framebuffer bank (top/bottom arrays), single write port, registered {top,bottom} read; ports: i clk/rst/we/we_bot/we_both/waddr/wdata/re/raddr, o rdata_top/rdata_bot
module fb_bank import hub75_pkg::*; #(
  parameter int DEPTH = DEF_HALF_ROWS * DEF_COLS,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          we_bot,
  input  logic          we_both,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata_top,
  output logic [2:0]    rdata_bot
);
  rgb_t r_top [DEPTH];
  rgb_t r_bot [DEPTH];
  rgb_t r_rd_top, r_rd_bot;
  always_ff @(posedge clk) begin
    if (we && (we_both || !we_bot)) r_top[waddr] <= wdata;
    if (we && (we_both || we_bot)) r_bot[waddr] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_top <= '0;
      r_rd_bot <= '0;
    end else if (re) begin
      r_rd_top <= r_top[raddr];
      r_rd_bot <= r_bot[raddr];
    end
  end
  assign rdata_top = r_rd_top;
  assign rdata_bot = r_rd_bot;
endmodule

// File: rtl/hub75_framebuffer.sv
// hub75_framebuffer: double-buffered HUB75 pixel store; host writes/clears back bank, scan reads front bank, swap at frame_end
// ports: clk, rst, host write (wr_*), clear (clr_*), swap (swap_req/frame_end/swap_done), busy, front_bank, scan read (rd_*)
module hub75_framebuffer import hub75_pkg::*; #(
  parameter int COLS = DEF_COLS,
  parameter int HALF_ROWS = DEF_HALF_ROWS,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(HALF_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [COL_W-1:0] wr_x,
  input  logic [ROW_W:0]   wr_y,
  input  logic [2:0]       wr_rgb,
  input  logic             clr_req,
  input  logic [2:0]       clr_rgb,
  input  logic             swap_req,
  input  logic             frame_end,
  output logic             swap_done,
  output logic             busy,
  output logic             front_bank,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic             rd_valid,
  output logic [2:0]       rd_rgb0,
  output logic [2:0]       rd_rgb1
);
  localparam int AW = ROW_W + COL_W;
  localparam int DEPTH = HALF_ROWS * COLS;
  fb_state_t r_state, w_next;
  logic r_front, r_pend, r_swap_done, r_rd_valid, r_rd_sel;
  rgb_t r_clr_rgb;
  logic [AW-1:0] r_cnt;
  logic w_clear, w_last, w_acc, w_we, w_swap;
  logic [AW-1:0] w_waddr;
  rgb_t w_wdata;
  logic [2:0] w_top0, w_bot0, w_top1, w_bot1;
  assign w_clear = (r_state == CLEAR);
  assign w_last = (r_cnt == AW'(DEPTH - 1));
  assign w_acc = wr_valid && (r_state == IDLE);
  assign w_swap = (r_state == SWAP_WAIT) && frame_end;
  assign w_we = w_acc || w_clear;
  assign w_waddr = w_clear ? r_cnt : {wr_y[ROW_W-1:0], wr_x};
  assign w_wdata = w_clear ? r_clr_rgb : wr_rgb;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = clr_req ? CLEAR : swap_req ? SWAP_WAIT : IDLE;
    else if (r_state == CLEAR) w_next = w_last ? ((r_pend || swap_req) ? SWAP_WAIT : IDLE) : CLEAR;
    else w_next = frame_end ? IDLE : SWAP_WAIT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_front <= 1'b0;
      r_pend <= 1'b0;
      r_swap_done <= 1'b0;
      r_clr_rgb <= '0;
      r_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_state <= w_next;
      r_swap_done <= w_swap;
      r_rd_valid <= rd_en;
      if (w_swap) r_front <= ~r_front;
      if (rd_en) r_rd_sel <= r_front;
      if (r_state == IDLE && clr_req) begin
        r_clr_rgb <= clr_rgb;
        r_cnt <= '0;
        r_pend <= swap_req;
      end else if (w_clear) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (swap_req) r_pend <= 1'b1;
      end else if (w_swap) r_pend <= 1'b0;
    end
  end
  // back bank is the one not displayed; both banks read on rd_en, front chosen by the bank sampled with the request
  fb_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(clk), .rst(rst), .we(w_we && r_front), .we_bot(wr_y[ROW_W]), .we_both(w_clear),
    .waddr(w_waddr), .wdata(w_wdata), .re(rd_en), .raddr({rd_row, rd_col}),
    .rdata_top(w_top0), .rdata_bot(w_bot0)
  );
  fb_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(clk), .rst(rst), .we(w_we && !r_front), .we_bot(wr_y[ROW_W]), .we_both(w_clear),
    .waddr(w_waddr), .wdata(w_wdata), .re(rd_en), .raddr({rd_row, rd_col}),
    .rdata_top(w_top1), .rdata_bot(w_bot1)
  );
  assign wr_ready = (r_state == IDLE);
  assign busy = (r_state != IDLE);
  assign front_bank = r_front;
  assign swap_done = r_swap_done;
  assign rd_valid = r_rd_valid;
  assign rd_rgb0 = r_rd_sel ? w_top1 : w_top0;
  assign rd_rgb1 = r_rd_sel ? w_bot1 : w_bot0;
endmodule

// File: doc/hub75_framebuffer.md
Name: hub75_framebuffer

Overview:
- Double-buffered pixel store feeding the HUB75 matrix driver; sits directly upstream of it.
- The host side writes pixels and clear commands into the back bank.
- The driver's scan side reads one top/bottom RGB pair per shift clock from the front bank.
- On request, the banks swap at the next frame boundary signalled by the driver, so no frame is ever displayed half-drawn.

Parameters:
- COLS, 32, pixels per shifted line (matches driver shift length).
- HALF_ROWS, 8, scanned row addresses (A/B/C); the panel has 2*HALF_ROWS lines.
- COL_W, $clog2(COLS), column index width.
- ROW_W, $clog2(HALF_ROWS), scan-row index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  host pixel write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  COL_W  pixel column.
- wr_y  in  ROW_W+1  pixel line; MSB=1 selects bottom half (RGB1).
- wr_rgb  in  3  {B,G,R} pixel value.
- clr_req  in  1  one-cycle pulse: fill back bank with clr_rgb.
- clr_rgb  in  3  fill colour, sampled with clr_req.
- swap_req  in  1  one-cycle pulse: swap banks at next frame_end.
- frame_end  in  1  one-cycle pulse from driver after last row latched.
- swap_done  out  1  one-cycle pulse when banks have swapped.
- busy  out  1  clear or swap in progress.
- front_bank  out  1  index of bank currently displayed.
- rd_en  in  1  scan read strobe.
- rd_row  in  ROW_W  scan row address.
- rd_col  in  COL_W  scan column.
- rd_valid  out  1  read data valid.
- rd_rgb0  out  3  top-half pixel {B,G,R}.
- rd_rgb1  out  3  bottom-half pixel {B,G,R}.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, front_bank=0, busy=0, swap_done=0.
  - rd_valid=0, rd_rgb0=0, rd_rgb1=0, swap-pending flag=0.
  - Memory contents are not reset.
- Storage:
  - Two banks; each holds a top array and a bottom array of HALF_ROWS*COLS 3-bit words, addressed {row,col}.
  - A pixel write touches one array only, so there is no read-modify-write.
- Read path:
  - Always serves the front bank; it is independent of the state machine.
  - Latency 1: rd_en at cycle t gives rd_valid=1 and rd_rgb0/rd_rgb1 at t+1.
  - With rd_en=0, rd_valid=0 and the data outputs hold their last value.
  - The front bank is sampled at t; a rd_en coinciding with the swap edge returns old-bank data.
- State machine: IDLE, CLEAR, SWAP_WAIT.
  - wr_ready = (state==IDLE), decoded from the state register with no combinational input path; it is 1 right after reset.
  - busy = (state!=IDLE).
- IDLE:
  - An accepted write stores wr_rgb into back bank (~front_bank) at {wr_y[ROW_W-1:0], wr_x}; the half is selected by wr_y[ROW_W].
  - clr_req: capture clr_rgb, set address counter=0, go to CLEAR.
  - swap_req: go to SWAP_WAIT.
  - clr_req and swap_req together: CLEAR, with swap pending.
  - Write accepted in the same cycle as clr_req: it is performed, then overwritten by the clear.
- CLEAR:
  - Each cycle writes the captured colour to both top and bottom arrays of the back bank at the counter address, then increments the counter.
  - Lasts exactly HALF_ROWS*COLS cycles (256 by default).
  - Counter wraps to 0 at the end; next state is SWAP_WAIT if a swap is pending, else IDLE.
  - clr_req while in CLEAR is ignored.
  - swap_req while in CLEAR sets swap pending.
- SWAP_WAIT:
  - On the first frame_end sampled while in SWAP_WAIT: front_bank toggles, swap_done=1 for one cycle (both at the next edge), state goes to IDLE, pending is cleared.
  - A frame_end in the same cycle as swap_req in IDLE is not used; the swap waits for the next frame_end.
  - clr_req and swap_req in SWAP_WAIT are ignored.
- Reset mid-CLEAR or mid-SWAP_WAIT: the operation is aborted, the back bank may be partially cleared, and front_bank returns to 0.

Decomposition:
- Shared package hub75_pkg:
  - COLS/HALF_ROWS defaults and derived widths.
  - rgb_t (3-bit {B,G,R}).
  - fb_state_t enum {IDLE, CLEAR, SWAP_WAIT}.
- One sub-module, fb_bank: one bank with a single write port (top/bottom select plus an "both" flag for clear) and a single synchronous read port returning a {top,bottom} pair.
- Instantiated twice; the top level muxes the write-enable to the back bank and the read data from the front bank.

Test Plan:
- Reset, then clr_req with clr_rgb=3'b000, swap_req, and clr_req with clr_rgb=3'b000 again -> busy=1 for 256 cycles each, wr_ready=0 throughout; after the second, both banks read 0.
- Write (x=5, y=0, rgb=3'b111) and (x=5, y=8, rgb=3'b001), swap_req, frame_end -> swap_done one cycle, front_bank=1; rd_en row0 col5 gives next cycle rd_rgb0=3'b111, rd_rgb1=3'b001; col4 gives 0/0.
- swap_req and frame_end in the same cycle -> no swap; second frame_end 10 cycles later -> front_bank toggles one cycle after it, swap_done pulses.
- rd_en held every cycle across the swap edge -> read at the frame_end cycle returns old-bank data; the next read returns new-bank data.
- clr_req(3'b100) then swap_req 3 cycles later -> CLEAR runs the full 256 cycles, then SWAP_WAIT; frame_end at cycle 100 is ignored (still CLEAR); first frame_end after clear completion swaps; all front pixels read 3'b100.
- Assert rst at cycle 50 of a CLEAR -> busy=0, front_bank=0, wr_ready=1 immediately; rd_valid=0.
